// File: rtl/set_pkg.sv
// set_pkg: shared definitions for the SET host and its watchdog.
// Contents: FSM state encoding, SET mode codes, default watchdog limit.
package set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] MODE_A   = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_MAJ = 2'd3;

    localparam int TIMEOUT_CYCLES_DEFAULT = 100;
    localparam int WDOG_W                 = 8;

endpackage

// File: rtl/set_host_wdog.sv
// set_host_wdog: 8-bit cycle watchdog for the SET host RUN phase.
// Ports: clk, rst_n; clear_i zeroes the count; enable_i counts one per cycle;
// limit_i is the abort threshold; expired_o flags the cycle the count reaches it.
module set_host_wdog
    import set_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [WDOG_W-1:0] limit_i,
    output logic              expired_o
);

    logic [WDOG_W-1:0] cnt_q;
    logic [WDOG_W-1:0] cnt_d;
    logic [WDOG_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_inc;
        end
    end

    // Fires on the edge that would make the count equal the limit.
    assign expired_o = enable_i && !clear_i && (cnt_inc == limit_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/set_host.sv
// set_host: single-outstanding host that feeds tasks to a SET engine.
// Ports: task_* upstream handshake and fields; en/central/radius/mode out to
// the engine, busy/valid/candidate back; res_* downstream result handshake;
// done_cnt counts delivered results. Macro SET_HOST_TIMEOUT_EN adds a RUN
// watchdog (TIMEOUT_CYCLES) that aborts with res_err=1, res_candidate=0.
module set_host
    import set_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        task_valid,
    output logic        task_ready,
    input  logic [23:0] task_central,
    input  logic [11:0] task_radius,
    input  logic [1:0]  task_mode,
    input  logic [3:0]  task_tag,
    output logic        en,
    output logic [23:0] central,
    output logic [11:0] radius,
    output logic [1:0]  mode,
    input  logic        busy,
    input  logic        valid,
    input  logic [7:0]  candidate,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_candidate,
    output logic [3:0]  res_tag,
    output logic        res_err,
    output logic [15:0] done_cnt
);

    // The watchdog is 8 bits wide and a limit of 1 would expire in LAUNCH.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_limit
        $error("set_host: TIMEOUT_CYCLES must be in 2..255");
    end

    state_e      state_q;
    logic        live_q;
    logic        en_q;
    logic [23:0] central_q;
    logic [11:0] radius_q;
    logic [1:0]  mode_q;
    logic [3:0]  tag_q;
    logic [7:0]  cand_q;
    logic [15:0] done_q;
    logic [15:0] done_d;
    logic        accept;
    logic        wd_expired;

    // live_q keeps task_ready low until the first edge after reset release.
    assign task_ready = (state_q == ST_IDLE) && live_q && !busy;
    assign accept     = task_valid && task_ready;
    assign done_d     = done_q + 16'd1;

    assign en            = en_q;
    assign central       = central_q;
    assign radius        = radius_q;
    assign mode          = mode_q;
    assign res_valid     = (state_q == ST_RESP);
    assign res_candidate = cand_q;
    assign res_tag       = tag_q;
    assign done_cnt      = done_q;

`ifdef SET_HOST_TIMEOUT_EN
    localparam logic [WDOG_W-1:0] WD_LIMIT = WDOG_W'(TIMEOUT_CYCLES);

    logic wd_clear;
    logic wd_enable;
    logic err_q;

    // Counting starts with the en cycle (LAUNCH) and continues through RUN.
    assign wd_clear  = (state_q == ST_IDLE);
    assign wd_enable = (state_q == ST_LAUNCH) || (state_q == ST_RUN);

    set_host_wdog u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (WD_LIMIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RUN) begin
            if (valid) begin
                err_q <= 1'b0;
            end else if (wd_expired) begin
                err_q <= 1'b1;
            end
        end
    end

    assign res_err = err_q;
`else
    assign wd_expired = 1'b0;
    assign res_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            live_q    <= 1'b0;
            en_q      <= 1'b0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            tag_q     <= '0;
            cand_q    <= '0;
            done_q    <= '0;
        end else begin
            live_q <= 1'b1;
            en_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        central_q <= task_central;
                        radius_q  <= task_radius;
                        mode_q    <= task_mode;
                        tag_q     <= task_tag;
                        en_q      <= 1'b1;
                        state_q   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    // A real result beats a coincident timeout.
                    if (valid) begin
                        cand_q  <= candidate;
                        state_q <= ST_RESP;
                    end else if (wd_expired) begin
                        cand_q  <= '0;
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (res_ready) begin
                        done_q  <= done_d;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_host.sv
// tb_set_host: randomized scoreboard bench for set_host with a SET engine model.
// The engine computes real SET counts on a 16x16 grid; results are checked in order.
module tb_set_host;
    import set_pkg::*;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        task_valid;
    logic        task_ready;
    logic [23:0] task_central;
    logic [11:0] task_radius;
    logic [1:0]  task_mode;
    logic [3:0]  task_tag;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_candidate;
    logic [3:0]  res_tag;
    logic        res_err;
    logic [15:0] done_cnt;

    set_host #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .task_valid    (task_valid),
        .task_ready    (task_ready),
        .task_central  (task_central),
        .task_radius   (task_radius),
        .task_mode     (task_mode),
        .task_tag      (task_tag),
        .en            (en),
        .central       (central),
        .radius        (radius),
        .mode          (mode),
        .busy          (busy),
        .valid         (valid),
        .candidate     (candidate),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_candidate (res_candidate),
        .res_tag       (res_tag),
        .res_err       (res_err),
        .done_cnt      (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tag;
        logic [7:0] cand;
        logic       err;
    } exp_t;

    typedef struct {
        int lat;
        bit hang;
    } eng_t;

    exp_t        exp_q[$];
    eng_t        eng_q[$];
    int          hs_cyc_q[$];
    int          en_cyc_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          en_count = 0;
    int          rv_seen = 0;
    int          rv_first_cyc = 0;
    int          en_last_cyc = 0;
    int          rst_epoch = 0;
    int          rr_mode = 0;
    bit          spur_req = 0;
    logic [15:0] exp_done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Count of grid points selected by the mode over three circles.
    function automatic int set_count(input logic [23:0] c, input logic [11:0] r,
                                     input logic [1:0] m);
        int n = 0;
        int cx, cy, rr, hits;
        bit in_c[3];
        bit sel;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int k = 0; k < 3; k++) begin
                    cx = int'(c[23-8*k -: 4]);
                    cy = int'(c[19-8*k -: 4]);
                    rr = int'(r[11-4*k -: 4]);
                    in_c[k] = ((x-cx)*(x-cx) + (y-cy)*(y-cy)) <= rr*rr;
                end
                hits = int'(in_c[0]) + int'(in_c[1]) + int'(in_c[2]);
                case (m)
                    MODE_A:   sel = in_c[0];
                    MODE_AND: sel = in_c[0] && in_c[1];
                    MODE_XOR: sel = in_c[0] ^ in_c[1];
                    default:  sel = hits >= 2;
                endcase
                if (sel) n++;
            end
        end
        return n % 256;
    endfunction

    task automatic send(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                        input logic [3:0] t, input int lat, input bit hang, input bit keep);
        int k = 0;
        exp_t e;
        eng_t j;
        @(negedge clk);
        task_valid   = 1'b1;
        task_central = c;
        task_radius  = r;
        task_mode    = m;
        task_tag     = t;
        #1;
        while (!task_ready && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!task_ready) begin
            chk("accept_wait", task_ready, 1);
            task_valid = 1'b0;
            return;
        end
        e.tag  = t;
        e.cand = hang ? 8'd0 : 8'(set_count(c, r, m));
        e.err  = hang;
        exp_q.push_back(e);
        j.lat  = lat;
        j.hang = hang;
        eng_q.push_back(j);
        @(posedge clk);
        if (!keep) begin
            @(negedge clk);
            task_valid = 1'b0;
        end
    endtask

    task automatic wait_hs(input int target, input int bound);
        int k = 0;
        while (hs_count < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        #2;
        chk("handshakes_reached", hs_count, target);
    endtask

    // res_ready driver: 0 = always 1, 1 = always 0, 2 = random.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rr_mode == 0) res_ready = 1'b1;
            else if (rr_mode == 1) res_ready = 1'b0;
            else res_ready = 1'($urandom_range(0, 1));
        end
    end

    // SET engine model: busy from en until its result strobe.
    initial begin
        eng_t        job;
        int          left = 0;
        int          res = 0;
        int          epoch = 0;
        bit          hang = 0;
        logic [37:0] f = '0;
        busy = 1'b0;
        valid = 1'b0;
        candidate = '0;
        forever begin
            @(negedge clk);
            valid = 1'b0;
            candidate = 8'($urandom);
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    busy = 1'b0;
                    if (!hang) begin
                        valid = 1'b1;
                        candidate = 8'(res);
                        if (epoch == rst_epoch)
                            chk("fields_held", {central, radius, mode}, f);
                    end
                end
            end else if (spur_req) begin
                valid = 1'b1;
                spur_req = 1'b0;
            end
            if (en) begin
                if (eng_q.size() == 0) begin
                    chk("en_without_task", eng_q.size(), 1);
                end else begin
                    job   = eng_q.pop_front();
                    left  = job.lat;
                    hang  = job.hang;
                    epoch = rst_epoch;
                    f     = {central, radius, mode};
                    res   = set_count(central, radius, mode);
                    busy  = 1'b1;
                end
            end
        end
    end

    // Monitor: en pulse shape, result scoreboard, payload stability.
    initial begin
        exp_t        e;
        logic [12:0] held = '0;
        bit          was = 0;
        bit          prev_en = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                was = 0;
                prev_en = 0;
                continue;
            end
            if (en) begin
                chk("en_one_cycle", prev_en, 0);
                en_count++;
                en_last_cyc = cyc;
                en_cyc_q.push_back(cyc);
            end
            prev_en = en;
            if (res_valid) begin
                rv_seen++;
                chk("ready_low_in_resp", task_ready, 0);
                if (was) chk("payload_stable", {res_tag, res_candidate, res_err}, held);
                else rv_first_cyc = cyc;
                held = {res_tag, res_candidate, res_err};
                was = 1;
                if (res_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("res_tag", res_tag, e.tag);
                        chk("res_candidate", res_candidate, e.cand);
                        chk("res_err", res_err, e.err);
                    end
                    chk("done_cnt", done_cnt, exp_done);
                    exp_done = exp_done + 16'd1;
                    hs_count++;
                    hs_cyc_q.push_back(cyc);
                    was = 0;
                end
            end else begin
                was = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: run exceeded time bound");
        $fatal(1, "tb_set_host: time bound exceeded");
    end

    initial begin
        int          b, e0, r0;
        int          k;
        logic [15:0] d0;
        rst_n = 1'b1;
        task_valid = 1'b0;
        task_central = '0;
        task_radius = '0;
        task_mode = '0;
        task_tag = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_task_ready", task_ready, 0);
        chk("rst_en", en, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_err", res_err, 0);
        chk("rst_res_candidate", res_candidate, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_done_cnt", done_cnt, 0);
        chk("rst_fields", {central, radius, mode}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", task_ready, 0);
        @(negedge clk);
        #1;
        chk("ready_after_release", task_ready, 1);

        // Single directed task, engine latency 66.
        en_count = 0;
        send(24'h440000, 12'h200, MODE_A, 4'd5, 66, 0, 0);
        wait_hs(1, 300);
        chk("done_cnt_one", done_cnt, 1);
        chk("en_pulses_one", en_count, 1);

        // Downstream stall for 20 cycles with a second task waiting.
        rr_mode = 1;
        b = hs_count;
        send(24'h3A5C71, 12'h534, MODE_XOR, 4'd9, 4, 0, 1);
        fork
            send(24'h88F0E2, 12'h772, MODE_MAJ, 4'd10, 4, 0, 0);
        join_none
        k = 0;
        while (!res_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        e0 = en_count;
        repeat (20) @(negedge clk);
        #2;
        chk("stall_res_valid", res_valid, 1);
        chk("stall_no_handshake", hs_count, b);
        chk("stall_no_en", en_count, e0);
        rr_mode = 0;
        wait_hs(b + 2, 400);

        // Back-to-back tasks: second en exactly 2 cycles after handshake.
        hs_cyc_q.delete();
        en_cyc_q.delete();
        b = hs_count;
        send(24'h123456, 12'h345, MODE_AND, 4'd3, 6, 0, 1);
        send(24'hFEDCBA, 12'h9AB, MODE_A, 4'd12, 6, 0, 0);
        wait_hs(b + 2, 400);
        if (hs_cyc_q.size() >= 1 && en_cyc_q.size() >= 2)
            chk("b2b_en_gap", en_cyc_q[1] - hs_cyc_q[0], 2);
        else
            chk("b2b_en_records", en_cyc_q.size(), 2);

        // Spurious engine strobe while idle.
        @(negedge clk);
        r0 = rv_seen;
        d0 = done_cnt;
        spur_req = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        chk("spur_no_result", rv_seen, r0);
        chk("spur_done_cnt", done_cnt, d0);

`ifdef SET_HOST_TIMEOUT_EN
        // Engine never answers: watchdog abort after TO cycles.
        b = hs_count;
        send(24'h777777, 12'h333, MODE_MAJ, 4'd7, 150, 1, 0);
        wait_hs(b + 1, 400);
        chk("timeout_latency", rv_first_cyc - en_last_cyc, TO);
`endif

        // Randomized traffic with random downstream backpressure.
        rr_mode = 2;
        b = hs_count;
        for (int i = 0; i < 25; i++) begin
            send(24'($urandom), 12'($urandom), 2'($urandom), 4'($urandom),
                 $urandom_range(1, 12), 0, (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        wait_hs(b + 25, 4000);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_cnt_total", done_cnt, exp_done);

        // Reset in the middle of RUN; the late engine result must be ignored.
        rr_mode = 0;
        send(24'h5A5A5A, 12'h444, MODE_AND, 4'd14, 60, 0, 0);
        repeat (20) @(negedge clk);
        #2;
        rst_n = 1'b0;
        rst_epoch++;
        #1;
        chk("midrst_en", en, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_done_cnt", done_cnt, 0);
        chk("midrst_task_ready", task_ready, 0);
        chk("midrst_fields", {central, radius, mode}, 0);
        exp_q.delete();
        exp_done = '0;
        r0 = rv_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        #2;
        chk("late_valid_ignored", rv_seen, r0);
        chk("done_after_reset", done_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
